// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        FAULT
    } fetch_state_e;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        MISALIGN = 2'd1,
        TIMEOUT  = 2'd2
    } fault_cause_e;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding register for a fetched instruction and its PC.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    input  logic            ready,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr,
    output logic            free
);

    // Free means the slot is empty by the end of this cycle, so a refill may overlap a consume.
    assign free = !valid || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer: one outstanding imem request, redirects, drain and fault handling.
// States: IDLE post-reset gap | REQ issue fetch | WAIT await response | DRAIN drop stale response | FAULT halted until trap
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] BOOT_PC        = 32'h0000_0000,
    parameter int unsigned     TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            pc_en_o,
    output logic            imem_req_valid_o,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_req_ready_i,
    input  logic            imem_resp_valid_i,
    input  logic [XLEN-1:0] imem_resp_data_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_instr_o,
    output logic [XLEN-1:0] if_pc_o,
    input  logic            if_ready_i,
    input  logic            br_redirect_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_target_i,
    output logic            flush_o,
    output logic            fetch_fault_o,
    output logic [1:0]      fault_cause_o
);

    localparam logic [8:0] TMO_LIMIT = 9'(TIMEOUT_CYCLES);

    fetch_state_e    state_q, state_d;
    fault_cause_e    cause_q, cause_d;
    logic [XLEN-1:0] req_pc_q;
    logic [7:0]      tmo_cnt_q, tmo_cnt_d;
    logic            mis_pend_q, mis_pend_d;
    logic            buf_free, buf_load;
    logic            accept, redirect, waiting, timed_out, tgt_mis;
    logic [XLEN-1:0] redirect_tgt;

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        tmo_cnt_d  = tmo_cnt_q;
        mis_pend_d = mis_pend_q;

        waiting          = (state_q == WAIT) || (state_q == DRAIN);
        imem_req_valid_o = (state_q == REQ) && buf_free;
        imem_req_addr_o  = (state_q == REQ) ? pc_i : '0;
        accept           = imem_req_valid_o && imem_req_ready_i;

        redirect     = (state_q != IDLE) && (trap_i || (br_redirect_i && (state_q != FAULT)));
        redirect_tgt = trap_i ? trap_target_i : br_target_i;
        tgt_mis      = (redirect_tgt[1:0] != 2'b00);
        timed_out    = waiting && !imem_resp_valid_i && (TIMEOUT_CYCLES != 0)
                       && (({1'b0, tmo_cnt_q} + 9'd1) == TMO_LIMIT);
        buf_load     = (state_q == WAIT) && imem_resp_valid_i && !redirect;

        pc_en_o   = accept || redirect;
        flush_o   = redirect;
        next_pc_o = redirect ? redirect_tgt :
                    (state_q == IDLE) ? BOOT_PC : pc_i + PC_INC;

        if (redirect) begin
            // An escaped or in-flight request must be drained before the new target is fetched.
            tmo_cnt_d  = '0;
            mis_pend_d = tgt_mis;
            if (accept || (waiting && !imem_resp_valid_i)) begin
                state_d = DRAIN;
            end else if (tgt_mis) begin
                state_d = FAULT;
                cause_d = MISALIGN;
            end else begin
                state_d = REQ;
                cause_d = NONE;
            end
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (accept) begin
                        state_d   = WAIT;
                        tmo_cnt_d = '0;
                    end
                end
                WAIT, DRAIN: begin
                    if (imem_resp_valid_i) begin
                        tmo_cnt_d = '0;
                        if ((state_q == DRAIN) && mis_pend_q) begin
                            state_d = FAULT;
                            cause_d = MISALIGN;
                        end else begin
                            state_d = REQ;
                        end
                    end else if (timed_out) begin
                        tmo_cnt_d = '0;
                        state_d   = FAULT;
                        cause_d   = TIMEOUT;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 8'd1;
                    end
                end
                FAULT: state_d = FAULT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cause_q    <= NONE;
            req_pc_q   <= '0;
            tmo_cnt_q  <= '0;
            mis_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            tmo_cnt_q  <= tmo_cnt_d;
            mis_pend_q <= mis_pend_d;
            if (accept) begin
                req_pc_q <= pc_i;
            end
        end
    end

    assign fetch_fault_o = (state_q == FAULT);
    assign fault_cause_o = cause_q;

    fetch_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .clr        (redirect),
        .load       (buf_load),
        .load_pc    (req_pc_q),
        .load_instr (imem_resp_data_i),
        .ready      (if_ready_i),
        .valid      (if_valid_o),
        .pc         (if_pc_o),
        .instr      (if_instr_o),
        .free       (buf_free)
    );

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] BOOT_PC = 32'h0000_0000;
    localparam int          TMO     = 4;
    localparam logic [31:0] KEY     = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_reg;
    logic [31:0] next_pc_o, imem_req_addr_o, imem_resp_data_i, if_instr_o, if_pc_o;
    logic [31:0] br_target_i, trap_target_i;
    logic        pc_en_o, imem_req_valid_o, imem_req_ready_i, imem_resp_valid_i;
    logic        if_valid_o, if_ready_i, br_redirect_i, trap_i, flush_o, fetch_fault_o;
    logic [1:0]  fault_cause_o;

    int checks = 0;
    int errors = 0;

    // behavioural model: outstanding/discard flags instead of a state machine
    bit          m_started, m_out, m_discard, m_fault, m_pend, b_v;
    int          m_cause, m_cnt;
    logic [31:0] m_pc, m_req_pc, b_pc, b_instr;

    bit          mem_pend, mem_never, saw_accept;
    int          mem_lat, lat_min, lat_max;
    logic [31:0] mem_addr;
    logic [31:0] seen_pc[$];
    logic [31:0] seen_instr[$];

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_reg <= BOOT_PC;
        else if (pc_en_o) pc_reg <= next_pc_o;
    end

    fetch_pc_ctrl #(.BOOT_PC(BOOT_PC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .pc_i              (pc_reg),
        .next_pc_o         (next_pc_o),
        .pc_en_o           (pc_en_o),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_addr_o   (imem_req_addr_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_resp_valid_i (imem_resp_valid_i),
        .imem_resp_data_i  (imem_resp_data_i),
        .if_valid_o        (if_valid_o),
        .if_instr_o        (if_instr_o),
        .if_pc_o           (if_pc_o),
        .if_ready_i        (if_ready_i),
        .br_redirect_i     (br_redirect_i),
        .br_target_i       (br_target_i),
        .trap_i            (trap_i),
        .trap_target_i     (trap_target_i),
        .flush_o           (flush_o),
        .fetch_fault_o     (fetch_fault_o),
        .fault_cause_o     (fault_cause_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_out = 0; m_discard = 0; m_fault = 0; m_pend = 0; b_v = 0;
        m_cause = 0; m_cnt = 0; m_pc = BOOT_PC; m_req_pc = '0; b_pc = '0; b_instr = '0;
    endtask

    // Called at posedge+1 with inputs set; compares at the falling edge, advances the model.
    task automatic cycle();
        bit can_req, e_req, e_acc, redir, mis, e_en, still, resp;
        logic [31:0] tgt, e_next, old_pc;
        #4;
        can_req = m_started && !m_fault && !m_out;
        e_req   = can_req && (!b_v || if_ready_i);
        e_acc   = e_req && imem_req_ready_i;
        redir   = m_started && (trap_i || (br_redirect_i && !m_fault));
        tgt     = trap_i ? trap_target_i : br_target_i;
        mis     = (tgt[1:0] != 2'b00);
        e_en    = e_acc || redir;
        e_next  = redir ? tgt : m_pc + 32'd4;
        resp    = imem_resp_valid_i;

        chk("pc_reg", pc_reg, m_pc);
        chk("if_valid", 32'(if_valid_o), 32'(b_v));
        if (b_v) begin
            chk("if_pc", if_pc_o, b_pc);
            chk("if_instr", if_instr_o, b_instr);
        end
        chk("req_valid", 32'(imem_req_valid_o), 32'(e_req));
        if (e_req) chk("req_addr", imem_req_addr_o, m_pc);
        chk("pc_en", 32'(pc_en_o), 32'(e_en));
        if (e_en) chk("next_pc", next_pc_o, e_next);
        chk("flush", 32'(flush_o), 32'(redir));
        chk("fault", 32'(fetch_fault_o), 32'(m_fault));
        chk("cause", 32'(fault_cause_o), 32'(m_cause));

        saw_accept = imem_req_valid_o && imem_req_ready_i;
        if (if_valid_o && if_ready_i) begin
            seen_pc.push_back(if_pc_o);
            seen_instr.push_back(if_instr_o);
        end
        if (saw_accept) begin
            mem_pend = 1;
            mem_addr = imem_req_addr_o;
            mem_lat  = mem_never ? 1000000 : int'($urandom_range(lat_min, lat_max));
        end

        old_pc = m_pc;
        if (!m_started) m_started = 1;
        if (e_en) m_pc = e_next;
        if (redir) b_v = 0;
        else begin
            if (b_v && if_ready_i) b_v = 0;
            if (m_out && !m_discard && resp) begin
                b_v = 1; b_pc = m_req_pc; b_instr = imem_resp_data_i;
            end
        end
        if (redir) begin
            still = e_acc || (m_out && !resp);
            m_cnt = 0;
            if (still) begin
                m_out = 1; m_discard = 1; m_pend = mis;
            end else begin
                m_out = 0; m_fault = mis; m_cause = mis ? 1 : 0;
            end
        end else if (e_acc) begin
            m_out = 1; m_discard = 0; m_req_pc = old_pc; m_cnt = 0;
        end else if (m_out && resp) begin
            m_out = 0; m_cnt = 0;
            if (m_discard && m_pend) begin m_fault = 1; m_cause = 1; end
        end else if (m_out) begin
            m_cnt++;
            if (m_cnt == TMO) begin m_out = 0; m_fault = 1; m_cause = 2; m_cnt = 0; end
        end

        @(posedge clk);
        #1;
        imem_resp_valid_i = 1'b0;
        imem_resp_data_i  = $urandom;
        if (mem_pend) begin
            mem_lat--;
            if (mem_lat == 0) begin
                imem_resp_valid_i = 1'b1;
                imem_resp_data_i  = mem_addr ^ KEY;
                mem_pend = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        br_redirect_i = 0; trap_i = 0; imem_resp_valid_i = 0;
        #1;
        chk("rst_if_valid", 32'(if_valid_o), 0);
        chk("rst_req_valid", 32'(imem_req_valid_o), 0);
        chk("rst_req_addr", imem_req_addr_o, 0);
        chk("rst_pc_en", 32'(pc_en_o), 0);
        chk("rst_next_pc", next_pc_o, BOOT_PC);
        chk("rst_flush", 32'(flush_o), 0);
        chk("rst_fault", 32'(fetch_fault_o), 0);
        chk("rst_cause", 32'(fault_cause_o), 0);
        chk("rst_if_pc", if_pc_o, 0);
        chk("rst_if_instr", if_instr_o, 0);
        model_reset();
        mem_pend = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] p0;
        imem_req_ready_i = 1; if_ready_i = 1; br_redirect_i = 0; trap_i = 0;
        br_target_i = '0; trap_target_i = '0; imem_resp_valid_i = 0; imem_resp_data_i = '0;
        lat_min = 1; lat_max = 1; mem_never = 0; saw_accept = 0;
        #1;
        do_reset();

        // straight-line fetch with a one-cycle memory
        repeat (14) cycle();
        chk("seen_ge3", 32'(seen_pc.size() >= 3), 1);
        if (seen_pc.size() >= 3) begin
            chk("first_pc0", seen_pc[0], 32'h0);
            chk("first_pc1", seen_pc[1], 32'h4);
            chk("first_pc2", seen_pc[2], 32'h8);
            chk("first_instr0", seen_instr[0], 32'h1357_9BDF);
        end

        // decode backpressure
        if_ready_i = 0;
        n = 0;
        while (!b_v && n < 10) begin cycle(); n++; end
        chk("bp_fill_wait", 32'(n < 10), 1);
        p0 = pc_reg;
        repeat (6) cycle();
        chk("bp_pc_frozen", pc_reg, p0);
        if_ready_i = 1;
        cycle();
        chk("bp_release_req", 32'(saw_accept), 1);

        // branch while waiting; late response must be dropped
        lat_min = 3; lat_max = 3;
        n = 0;
        while (!(m_out && !m_discard) && n < 10) begin cycle(); n++; end
        chk("br_wait_reach", 32'(n < 10), 1);
        br_redirect_i = 1; br_target_i = 32'h100;
        cycle();
        br_redirect_i = 0;
        chk("br_pc", pc_reg, 32'h100);
        seen_pc.delete();
        n = 0;
        while (seen_pc.size() == 0 && n < 20) begin cycle(); n++; end
        chk("br_first_pc", (seen_pc.size() > 0) ? seen_pc[0] : 32'hFFFF_FFFF, 32'h100);

        // trap beats branch
        lat_min = 1; lat_max = 1;
        trap_i = 1; trap_target_i = 32'h200; br_redirect_i = 1; br_target_i = 32'h300;
        cycle();
        trap_i = 0; br_redirect_i = 0;
        chk("prio_pc", pc_reg, 32'h200);

        // misaligned branch, then recovery by trap
        br_redirect_i = 1; br_target_i = 32'h102;
        cycle();
        br_redirect_i = 0;
        chk("mis_pc", pc_reg, 32'h102);
        n = 0;
        while (!m_fault && n < 10) begin cycle(); n++; end
        chk("mis_cause", 32'(fault_cause_o), 1);
        chk("mis_fault", 32'(fetch_fault_o), 1);
        br_redirect_i = 1; br_target_i = 32'h400;
        repeat (3) cycle();
        br_redirect_i = 0;
        chk("fault_br_ignored", pc_reg, 32'h102);
        trap_i = 1; trap_target_i = 32'h80;
        cycle();
        trap_i = 0;
        chk("trap_pc", pc_reg, 32'h80);
        chk("trap_clears_fault", 32'(fetch_fault_o), 0);
        seen_pc.delete();
        n = 0;
        while (seen_pc.size() == 0 && n < 20) begin cycle(); n++; end
        chk("trap_first_pc", (seen_pc.size() > 0) ? seen_pc[0] : 32'hFFFF_FFFF, 32'h80);

        // PC increment wraps to zero
        trap_i = 1; trap_target_i = 32'hFFFF_FFFC;
        cycle();
        trap_i = 0;
        n = 0;
        do begin cycle(); n++; end while (!saw_accept && n < 20);
        chk("wrap_pc", pc_reg, 32'h0);

        // memory that never answers
        mem_never = 1;
        n = 0;
        do begin cycle(); n++; end while (!saw_accept && n < 20);
        chk("tmo_accept", 32'(saw_accept), 1);
        n = 0;
        while (!fetch_fault_o && n < 20) begin cycle(); n++; end
        chk("tmo_wait_cycles", 32'(n), 4);
        chk("tmo_cause", 32'(fault_cause_o), 2);

        // reset while a request is outstanding
        trap_i = 1; trap_target_i = 32'h40;
        cycle();
        trap_i = 0;
        n = 0;
        do begin cycle(); n++; end while (!saw_accept && n < 20);
        repeat (2) cycle();
        do_reset();
        mem_never = 0;

        // random traffic
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            int r;
            imem_req_ready_i = ($urandom_range(0, 9) < 7);
            if_ready_i       = ($urandom_range(0, 9) < 6);
            r = int'($urandom_range(0, 99));
            br_redirect_i    = (r < 5);
            trap_i           = (r >= 3 && r < 6) || (m_fault && r >= 90);
            br_target_i      = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            trap_target_i    = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            if ($urandom_range(0, 4) == 0) br_target_i[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 4) == 0) trap_target_i[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 999) == 0) do_reset();
            else cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
Sequencer for the fetch-stage PC register. It drives the register's next-PC value and load enable, and issues one outstanding instruction-memory request per PC. Each returned instruction is held in a one-entry buffer and presented to decode with a valid/ready handshake. Branch and trap redirects, in-flight response discard, misaligned-target faults and memory timeouts are handled here.

Parameters:
BOOT_PC, 32'h0000_0000, first fetch address after reset; must equal the PC register reset value.
TIMEOUT_CYCLES, 255, max cycles waiting for imem response (8-bit counter); 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
pc_i  in  32  current PC from PC register
next_pc_o  out  32  value to load into PC register
pc_en_o  out  1  PC register load enable
imem_req_valid_o  out  1  fetch request valid
imem_req_addr_o  out  32  fetch address (= pc_i)
imem_req_ready_i  in  1  memory accepts request
imem_resp_valid_i  in  1  response valid (single cycle, no backpressure)
imem_resp_data_i  in  32  instruction word
if_valid_o  out  1  buffered instruction valid to decode
if_instr_o  out  32  buffered instruction
if_pc_o  out  32  PC of buffered instruction
if_ready_i  in  1  decode consumes buffer
br_redirect_i  in  1  branch/jump redirect (pulse)
br_target_i  in  32  redirect target
trap_i  in  1  trap/return redirect (pulse)
trap_target_i  in  32  trap vector / mepc
flush_o  out  1  redirect taken this cycle
fetch_fault_o  out  1  fault latched (level)
fault_cause_o  out  2  0 none, 1 misaligned target, 2 timeout

Behaviour:
- States: IDLE, REQ, WAIT, DRAIN, FAULT.
- Reset:
  - state=IDLE.
  - All outputs 0, except next_pc_o=BOOT_PC.
  - Buffer empty; req_pc=0; timeout counter=0.
- IDLE: one cycle, then REQ.
- REQ:
  - imem_req_valid_o=1 only when the buffer is empty, or if_ready_i=1 this cycle.
  - imem_req_addr_o=pc_i.
- Request accept (valid & ready):
  - pc_en_o=1, next_pc_o=pc_i+4 (mod 2^32; wraps at 0xFFFF_FFFC→0).
  - req_pc<=pc_i; go to WAIT.
- WAIT:
  - On imem_resp_valid_i: buffer<= {req_pc, data}, if_valid_o=1 from the next cycle; go to REQ.
  - Counter increments each WAIT cycle. Reaching TIMEOUT_CYCLES → FAULT, cause=2.
- Buffer:
  - Holds its contents until if_valid_o & if_ready_i.
  - Consuming and refilling in the same cycle is legal.
  - Overflow is impossible because only one request is outstanding.
- pc_en_o and next_pc_o are combinational from state and inputs. pc_en_o=0 whenever no accept and no redirect.
- Redirect priority: trap_i > br_redirect_i. A redirect is taken in every state except IDLE, where redirects are ignored.
- Taken redirect:
  - pc_en_o=1, next_pc_o=target, flush_o=1 (same cycle).
  - Buffer cleared (if_valid_o=0 next cycle).
  - Timeout counter cleared.
- Next state after a redirect:
  - From REQ with imem_req_ready_i=0 → REQ.
  - From REQ with imem_req_ready_i=1 (request escaped) → DRAIN.
  - From WAIT without resp_valid → DRAIN.
  - From WAIT with resp_valid in the same cycle → REQ; the response is discarded.
  - From DRAIN with resp_valid → REQ; otherwise stay in DRAIN.
- DRAIN:
  - Discards the next response, then goes to REQ.
  - Timeout counter is active; timeout → FAULT, cause=2.
- Misaligned target (target[1:0]≠0):
  - PC is still loaded.
  - If nothing is outstanding → FAULT, cause=1.
  - If a request is outstanding → DRAIN first, then FAULT after the discard.
- FAULT:
  - No requests; fetch_fault_o=1.
  - Exited only by trap_i. An aligned trap target → REQ and clears the fault. A misaligned trap target stays in FAULT, cause=1.
  - br_redirect_i is ignored in FAULT.
- Reset mid-operation: immediate return to reset values. Any response arriving during or after reset is ignored until IDLE exits.

Decomposition:
- Package fetch_pkg:
  - fetch_state_e.
  - fault_cause_e (NONE, MISALIGN, TIMEOUT).
  - XLEN=32, PC_INC=4.
- Sub-module fetch_buffer: one-entry pc/instr holding register with valid/ready, clear input, and a "free" output used by REQ gating.

Test Plan:
- Reset, memory with always-ready and 1-cycle response → requests at 0x0,0x4,0x8. if_pc_o/if_instr_o match. pc_en_o pulses only on accepts.
- Hold if_ready_i=0 with buffer full → imem_req_valid_o=0 and pc_i frozen. Release → request issues the same cycle.
- br_redirect_i to 0x100 while in WAIT → flush_o=1, pc_i=0x100 next cycle. The late response to the old PC is dropped; the next if_pc_o=0x100.
- trap_i and br_redirect_i together (0x200 vs 0x300) → PC=0x200.
- Branch to 0x102 → fault cause 1, no requests. trap_i to 0x80 → fetch resumes at 0x80, fault cleared.
- TIMEOUT_CYCLES=4, memory never responds → FAULT, cause 2, after 4 WAIT cycles. Assert rst mid-WAIT → all outputs return to reset values immediately.
